// File: rtl/pe.sv
// Background-replacement processing element: a summing FSM that produces the
// per-channel floor mean of a packed pixel row, and an independent FSM that
// replaces pixels close to an expected colour with a programmable colour.
module pe #(
  parameter int NUM_PIXELS = 4
) (
  input  logic                    Clk,
  input  logic                    Ack,
  input  logic                    Reset,
  input  logic [7:0]              red_exp,
  input  logic [7:0]              green_exp,
  input  logic [7:0]              blue_exp,
  input  logic [7:0]              threshold,
  input  logic [7:0]              desired_bg_r,
  input  logic [7:0]              desired_bg_g,
  input  logic [7:0]              desired_bg_b,
  input  logic                    Start_Sum,
  input  logic                    Start_BgRemoval,
  input  logic [8*NUM_PIXELS-1:0] red_in,
  input  logic [8*NUM_PIXELS-1:0] green_in,
  input  logic [8*NUM_PIXELS-1:0] blue_in,
  output logic [8*NUM_PIXELS-1:0] red_out,
  output logic [8*NUM_PIXELS-1:0] green_out,
  output logic [8*NUM_PIXELS-1:0] blue_out,
  output logic                    Qi,
  output logic                    Qbgi,
  output logic                    Qbg,
  output logic                    Qbgd,
  output logic                    Qsi,
  output logic                    Qs,
  output logic                    Qsd,
  output logic [8*NUM_PIXELS-1:0] red_sum,
  output logic [8*NUM_PIXELS-1:0] green_sum,
  output logic [8*NUM_PIXELS-1:0] blue_sum
);

  localparam int DATA_W = 8;
  localparam int BUS_W  = DATA_W * NUM_PIXELS;
  localparam int ACC_W  = DATA_W + $clog2(NUM_PIXELS);
  localparam int IDX_W  = $clog2(NUM_PIXELS + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_PIXELS - 1);

  typedef enum logic [2:0] {
    S_INIT = 3'b001,
    S_RUN  = 3'b010,
    S_DONE = 3'b100
  } state_t;

  function automatic logic [DATA_W-1:0] pix_at(input logic [BUS_W-1:0] bus,
                                               input logic [IDX_W-1:0] idx);
    pix_at = '0;
    for (int i = 0; i < NUM_PIXELS; i++)
      if (idx == IDX_W'(i)) pix_at = bus[DATA_W*i +: DATA_W];
  endfunction

  function automatic logic [DATA_W-1:0] abs_diff(input logic [DATA_W-1:0] a,
                                                 input logic [DATA_W-1:0] b);
    logic signed [DATA_W:0] diff;
    diff = $signed({1'b0, a}) - $signed({1'b0, b});
    if (diff < 0) diff = -diff;
    return diff[DATA_W-1:0];
  endfunction

  function automatic logic [DATA_W-1:0] max3(input logic [DATA_W-1:0] a,
                                             input logic [DATA_W-1:0] b,
                                             input logic [DATA_W-1:0] c);
    logic [DATA_W-1:0] m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  function automatic logic [DATA_W-1:0] mean_of(input logic [ACC_W-1:0] acc);
    logic [ACC_W-1:0] q;
    q = acc / ACC_W'(NUM_PIXELS);
    return q[DATA_W-1:0];
  endfunction

  // ---------------- summing FSM ----------------
  state_t             sum_state;
  logic [IDX_W-1:0]   sum_idx;
  logic [BUS_W-1:0]   sum_r_lat, sum_g_lat, sum_b_lat;
  logic [ACC_W-1:0]   acc_r, acc_g, acc_b;
  logic [ACC_W-1:0]   acc_r_nxt, acc_g_nxt, acc_b_nxt;

  assign acc_r_nxt = acc_r + ACC_W'(pix_at(sum_r_lat, sum_idx));
  assign acc_g_nxt = acc_g + ACC_W'(pix_at(sum_g_lat, sum_idx));
  assign acc_b_nxt = acc_b + ACC_W'(pix_at(sum_b_lat, sum_idx));

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      sum_state <= S_INIT;
      sum_idx   <= '0;
      sum_r_lat <= '0;
      sum_g_lat <= '0;
      sum_b_lat <= '0;
      acc_r     <= '0;
      acc_g     <= '0;
      acc_b     <= '0;
      red_sum   <= '0;
      green_sum <= '0;
      blue_sum  <= '0;
    end else begin
      case (sum_state)
        S_INIT: if (Start_Sum) begin
          sum_r_lat <= red_in;
          sum_g_lat <= green_in;
          sum_b_lat <= blue_in;
          acc_r     <= '0;
          acc_g     <= '0;
          acc_b     <= '0;
          sum_idx   <= '0;
          sum_state <= S_RUN;
        end
        S_RUN: begin
          acc_r   <= acc_r_nxt;
          acc_g   <= acc_g_nxt;
          acc_b   <= acc_b_nxt;
          sum_idx <= sum_idx + 1'b1;
          // The last addition feeds the mean directly so done lands one edge earlier.
          if (sum_idx == LAST_IDX) begin
            red_sum   <= BUS_W'(mean_of(acc_r_nxt));
            green_sum <= BUS_W'(mean_of(acc_g_nxt));
            blue_sum  <= BUS_W'(mean_of(acc_b_nxt));
            sum_state <= S_DONE;
          end
        end
        S_DONE: if (Ack) sum_state <= S_INIT;
        default: sum_state <= S_INIT;
      endcase
    end
  end

  assign Qsi = sum_state[0];
  assign Qs  = sum_state[1];
  assign Qsd = sum_state[2];

  // ---------------- background-removal FSM ----------------
  state_t             bg_state;
  logic [IDX_W-1:0]   bg_idx;
  logic [BUS_W-1:0]   bg_r_lat, bg_g_lat, bg_b_lat;
  logic [DATA_W-1:0]  bg_er, bg_eg, bg_eb, bg_thr, bg_dr, bg_dg, bg_db;
  logic [DATA_W-1:0]  bg_r_pix, bg_g_pix, bg_b_pix, bg_dist;
  logic               bg_hit;

  assign bg_r_pix = pix_at(bg_r_lat, bg_idx);
  assign bg_g_pix = pix_at(bg_g_lat, bg_idx);
  assign bg_b_pix = pix_at(bg_b_lat, bg_idx);
  assign bg_dist  = max3(abs_diff(bg_r_pix, bg_er), abs_diff(bg_g_pix, bg_eg),
                         abs_diff(bg_b_pix, bg_eb));
  assign bg_hit   = bg_dist < bg_thr;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      bg_state  <= S_INIT;
      bg_idx    <= '0;
      bg_r_lat  <= '0;
      bg_g_lat  <= '0;
      bg_b_lat  <= '0;
      bg_er     <= '0;
      bg_eg     <= '0;
      bg_eb     <= '0;
      bg_thr    <= '0;
      bg_dr     <= '0;
      bg_dg     <= '0;
      bg_db     <= '0;
      red_out   <= '0;
      green_out <= '0;
      blue_out  <= '0;
    end else begin
      case (bg_state)
        S_INIT: if (Start_BgRemoval) begin
          bg_r_lat <= red_in;
          bg_g_lat <= green_in;
          bg_b_lat <= blue_in;
          bg_er    <= red_exp;
          bg_eg    <= green_exp;
          bg_eb    <= blue_exp;
          bg_thr   <= threshold;
          bg_dr    <= desired_bg_r;
          bg_dg    <= desired_bg_g;
          bg_db    <= desired_bg_b;
          bg_idx   <= '0;
          bg_state <= S_RUN;
        end
        S_RUN: begin
          for (int i = 0; i < NUM_PIXELS; i++) begin
            if (bg_idx == IDX_W'(i)) begin
              red_out[DATA_W*i +: DATA_W]   <= bg_hit ? bg_dr : bg_r_pix;
              green_out[DATA_W*i +: DATA_W] <= bg_hit ? bg_dg : bg_g_pix;
              blue_out[DATA_W*i +: DATA_W]  <= bg_hit ? bg_db : bg_b_pix;
            end
          end
          bg_idx <= bg_idx + 1'b1;
          if (bg_idx == LAST_IDX) bg_state <= S_DONE;
        end
        S_DONE: if (Ack) bg_state <= S_INIT;
        default: bg_state <= S_INIT;
      endcase
    end
  end

  assign Qbgi = bg_state[0];
  assign Qbg  = bg_state[1];
  assign Qbgd = bg_state[2];
  assign Qi   = Qsi & Qbgi;

endmodule

// File: tb/tb_pe.sv
// Bench for pe: directed scenarios plus randomized rows, checked against a
// behavioural model of the channel means and background substitution.
module tb_pe;
  localparam int NP = 4;
  localparam int BW = 8 * NP;

  logic          Clk, Ack, Reset, Start_Sum, Start_BgRemoval;
  logic [7:0]    red_exp, green_exp, blue_exp, threshold;
  logic [7:0]    desired_bg_r, desired_bg_g, desired_bg_b;
  logic [BW-1:0] red_in, green_in, blue_in, red_out, green_out, blue_out;
  logic [BW-1:0] red_sum, green_sum, blue_sum;
  logic          Qi, Qbgi, Qbg, Qbgd, Qsi, Qs, Qsd;

  pe #(.NUM_PIXELS(NP)) dut (
    .Clk(Clk), .Ack(Ack), .Reset(Reset),
    .red_exp(red_exp), .green_exp(green_exp), .blue_exp(blue_exp),
    .threshold(threshold),
    .desired_bg_r(desired_bg_r), .desired_bg_g(desired_bg_g), .desired_bg_b(desired_bg_b),
    .Start_Sum(Start_Sum), .Start_BgRemoval(Start_BgRemoval),
    .red_in(red_in), .green_in(green_in), .blue_in(blue_in),
    .red_out(red_out), .green_out(green_out), .blue_out(blue_out),
    .Qi(Qi), .Qbgi(Qbgi), .Qbg(Qbg), .Qbgd(Qbgd), .Qsi(Qsi), .Qs(Qs), .Qsd(Qsd),
    .red_sum(red_sum), .green_sum(green_sum), .blue_sum(blue_sum)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int n_cmp = 0;
  int n_err = 0;

  // Scenario data: pixel channels, expected colour, threshold, replacement.
  int pr[NP], pg[NP], pb[NP];
  int er, eg, eb, thr, dr, dg, db;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  function automatic int px(input int ch, input int i);
    case (ch)
      0: return pr[i];
      1: return pg[i];
      default: return pb[i];
    endcase
  endfunction

  function automatic int absd(input int a, input int b);
    return (a > b) ? a - b : b - a;
  endfunction

  function automatic int clamp8(input int v);
    return (v < 0) ? 0 : ((v > 255) ? 255 : v);
  endfunction

  function automatic logic [BW-1:0] model_mean(input int ch);
    int s;
    s = 0;
    for (int i = 0; i < NP; i++) s += px(ch, i);
    return BW'(s / NP);
  endfunction

  function automatic logic [BW-1:0] model_out(input int ch);
    logic [BW-1:0] o;
    int d, des;
    o = '0;
    des = (ch == 0) ? dr : ((ch == 1) ? dg : db);
    for (int i = 0; i < NP; i++) begin
      d = absd(pr[i], er);
      if (absd(pg[i], eg) > d) d = absd(pg[i], eg);
      if (absd(pb[i], eb) > d) d = absd(pb[i], eb);
      o[8*i +: 8] = 8'((d < thr) ? des : px(ch, i));
    end
    return o;
  endfunction

  task automatic apply();
    for (int i = 0; i < NP; i++) begin
      red_in[8*i +: 8]   = 8'(pr[i]);
      green_in[8*i +: 8] = 8'(pg[i]);
      blue_in[8*i +: 8]  = 8'(pb[i]);
    end
    red_exp = 8'(er); green_exp = 8'(eg); blue_exp = 8'(eb);
    threshold = 8'(thr);
    desired_bg_r = 8'(dr); desired_bg_g = 8'(dg); desired_bg_b = 8'(db);
  endtask

  task automatic corrupt();
    red_in = ~red_in; green_in = ~green_in; blue_in = ~blue_in;
    red_exp = ~red_exp; threshold = ~threshold; desired_bg_r = ~desired_bg_r;
  endtask

  // Start the selected FSMs and follow them to done, checking latency.
  task automatic run_wait(input bit s, input bit bg, input bit ack, input bit restart,
                          input string tag);
    Ack = ack;
    Start_Sum = s;
    Start_BgRemoval = bg;
    for (int k = 1; k <= NP + 1; k++) begin
      tick();
      if (k == 1 && restart) corrupt();
      else if ((k == 1 && !restart) || k == 2) begin
        Start_Sum = 1'b0;
        Start_BgRemoval = 1'b0;
        apply();
      end
      if (k <= NP) begin
        check({tag, "_qi_busy"}, Qi, 0);
        if (s)  begin check({tag, "_qs"}, Qs, 1);   check({tag, "_qsd_early"}, Qsd, 0); end
        if (bg) begin check({tag, "_qbg"}, Qbg, 1); check({tag, "_qbgd_early"}, Qbgd, 0); end
      end else begin
        if (s)  begin check({tag, "_qsd"}, Qsd, 1);   check({tag, "_qs_end"}, Qs, 0); end
        if (bg) begin check({tag, "_qbgd"}, Qbgd, 1); check({tag, "_qbg_end"}, Qbg, 0); end
      end
    end
  endtask

  task automatic check_sums(input string tag);
    check({tag, "_red_sum"},   red_sum,   model_mean(0));
    check({tag, "_green_sum"}, green_sum, model_mean(1));
    check({tag, "_blue_sum"},  blue_sum,  model_mean(2));
  endtask

  task automatic check_outs(input string tag);
    check({tag, "_red_out"},   red_out,   model_out(0));
    check({tag, "_green_out"}, green_out, model_out(1));
    check({tag, "_blue_out"},  blue_out,  model_out(2));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_qi"}, Qi, 1);     check({tag, "_qsi"}, Qsi, 1);   check({tag, "_qbgi"}, Qbgi, 1);
    check({tag, "_qs"}, Qs, 0);     check({tag, "_qsd"}, Qsd, 0);
    check({tag, "_qbg"}, Qbg, 0);   check({tag, "_qbgd"}, Qbgd, 0);
    check({tag, "_rsum"}, red_sum, 0); check({tag, "_gsum"}, green_sum, 0);
    check({tag, "_bsum"}, blue_sum, 0);
    check({tag, "_rout"}, red_out, 0); check({tag, "_gout"}, green_out, 0);
    check({tag, "_bout"}, blue_out, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout compared=%0d", n_cmp);
    $fatal(1, "watchdog");
  end

  initial begin
    Reset = 1'b1; Ack = 1'b0; Start_Sum = 1'b0; Start_BgRemoval = 1'b0;
    for (int i = 0; i < NP; i++) begin pr[i] = 0; pg[i] = 0; pb[i] = 0; end
    er = 0; eg = 0; eb = 0; thr = 0; dr = 0; dg = 0; db = 0;
    apply();
    repeat (5) tick();
    check_all_zero("reset");
    Reset = 1'b0;
    tick();
    check("post_reset_qi", Qi, 1);

    // Directed sum: pixel0 = (204,0,0), pixels 1..3 = (61,133,198).
    pr[0] = 204; pg[0] = 0; pb[0] = 0;
    for (int i = 1; i < NP; i++) begin pr[i] = 61; pg[i] = 133; pb[i] = 198; end
    er = 96; eg = 99; eb = 148; thr = 60; dr = 106; dg = 168; db = 79;
    apply();
    run_wait(1, 0, 1, 0, "dsum");
    check("dsum_red", red_sum, 96);
    check("dsum_green", green_sum, 99);
    check("dsum_blue", blue_sum, 148);
    check_sums("dsum_model");
    tick();
    check("dsum_back_init", Qsi, 1);
    check("dsum_hold_after_init", red_sum, 96);

    // Directed background removal on the same row.
    run_wait(0, 1, 1, 0, "dbg");
    check("dbg_red", red_out, 32'h6A6A6ACC);
    check("dbg_green", green_out, 32'hA8A8A800);
    check("dbg_blue", blue_out, 32'h4F4F4F00);
    check_outs("dbg_model");
    tick();
    check("dbg_back_init", Qbgi, 1);

    // Threshold boundary: pixel0 distance is exactly 40.
    pr[0] = 140; pg[0] = 90; pb[0] = 110;
    for (int i = 1; i < NP; i++) begin pr[i] = 0; pg[i] = 0; pb[i] = 0; end
    er = 100; eg = 100; eb = 100; thr = 40;
    apply();
    run_wait(0, 1, 1, 0, "thr_eq");
    check("thr_eq_px0_r", red_out[7:0], 140);
    check("thr_eq_px0_b", blue_out[7:0], 110);
    check_outs("thr_eq");
    tick();
    thr = 41;
    apply();
    run_wait(0, 1, 1, 0, "thr_p1");
    check("thr_p1_px0_r", red_out[7:0], 106);
    check("thr_p1_px0_g", green_out[7:0], 168);
    check_outs("thr_p1");
    tick();

    // Ack low in done: both FSMs and their outputs must hold.
    for (int i = 0; i < NP; i++) begin
      pr[i] = $urandom_range(0, 255); pg[i] = $urandom_range(0, 255); pb[i] = $urandom_range(0, 255);
    end
    er = pr[1]; eg = pg[1]; eb = pb[1]; thr = 30; dr = 1; dg = 2; db = 3;
    apply();
    run_wait(1, 1, 0, 0, "hold");
    for (int k = 0; k < 8; k++) begin
      tick();
      check("hold_qsd", Qsd, 1);
      check("hold_qbgd", Qbgd, 1);
    end
    corrupt();
    Start_Sum = 1'b1; Start_BgRemoval = 1'b1;
    tick();
    Start_Sum = 1'b0; Start_BgRemoval = 1'b0;
    apply();
    check("hold_start_ign_qsd", Qsd, 1);
    check("hold_start_ign_qbgd", Qbgd, 1);
    check_sums("hold");
    check_outs("hold");
    Ack = 1'b1;
    tick();
    Ack = 1'b0;
    check("ack_qsi", Qsi, 1);
    check("ack_qbgi", Qbgi, 1);
    check("ack_qi", Qi, 1);

    // Randomized concurrent runs, some with start pulses and input changes mid-run.
    for (int it = 0; it < 20; it++) begin
      er = $urandom_range(0, 255); eg = $urandom_range(0, 255); eb = $urandom_range(0, 255);
      for (int i = 0; i < NP; i++) begin
        pr[i] = clamp8(er + int'($urandom_range(0, 120)) - 60);
        pg[i] = clamp8(eg + int'($urandom_range(0, 120)) - 60);
        pb[i] = clamp8(eb + int'($urandom_range(0, 120)) - 60);
      end
      thr = (it == 0) ? 0 : ((it == 1) ? 255 : int'($urandom_range(0, 100)));
      dr = $urandom_range(0, 255); dg = $urandom_range(0, 255); db = $urandom_range(0, 255);
      apply();
      run_wait(1, 1, 1, (it % 3) == 0, "rnd");
      check_sums("rnd");
      check_outs("rnd");
      tick();
      check("rnd_idle", Qi, 1);
    end
    Ack = 1'b0;

    // Reset in the middle of a run.
    apply();
    Start_Sum = 1'b1; Start_BgRemoval = 1'b1;
    tick();
    Start_Sum = 1'b0; Start_BgRemoval = 1'b0;
    tick();
    check("midrst_running", Qs & Qbg, 1);
    #2 Reset = 1'b1;
    #1 check_all_zero("midrst");
    tick();
    Reset = 1'b0;
    tick();
    check("midrst_after_qi", Qi, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
